// File: rtl/updown_prescale_counter.sv
// Up/down modulo counter advanced by a clock-enable prescaler.
// Supports a synchronous load and wrap or saturate at the boundaries, with a one-cycle terminal-count pulse.
module updown_prescale_counter #(
  parameter int WIDTH  = 4,
  parameter int DIV    = 1,
  parameter int MODMAX = (2**WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             tc
);

  localparam int               PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PMAX  = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(MODMAX);
  localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
  localparam logic [PW-1:0]    P_ONE = PW'(1);

  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_out;
  logic             r_tc;
  logic             w_tick;
  logic [WIDTH-1:0] w_load;

  assign w_tick = en && (r_presc == PMAX);
  assign w_load = (load_val > W_MAX) ? W_MAX : load_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_presc <= '0;
    else if (load)
      r_presc <= '0;
    else if (en)
      r_presc <= (r_presc == PMAX) ? '0 : r_presc + P_ONE;
  end

  // Boundary steps raise tc whether they wrap or saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_out <= w_load;
      r_tc  <= 1'b0;
    end else if (w_tick) begin
      if (dir) begin
        if (r_out == W_MAX) begin
          r_out <= sat ? W_MAX : '0;
          r_tc  <= 1'b1;
        end else begin
          r_out <= r_out + W_ONE;
          r_tc  <= 1'b0;
        end
      end else begin
        if (r_out == '0) begin
          r_out <= sat ? '0 : W_MAX;
          r_tc  <= 1'b1;
        end else begin
          r_out <= r_out - W_ONE;
          r_tc  <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign out  = r_out;
  assign tick = w_tick;
  assign tc   = r_tc;

endmodule

// File: tb/tb_updown_prescale_counter.sv
// Directed bench for updown_prescale_counter using three parameterisations that share one stimulus bus.
module tb_updown_prescale_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b1, sat = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] a_out, b_out, c_out;
  logic       a_tick, b_tick, c_tick, a_tc, b_tc, c_tc;

  int n_chk  = 0;
  int n_fail = 0;
  int m_out, m_p;

  // a: free-running 0..15, b: modulo 10, c: divide-by-4
  updown_prescale_counter #(.WIDTH(4), .DIV(1), .MODMAX(15)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .out(a_out), .tick(a_tick), .tc(a_tc));
  updown_prescale_counter #(.WIDTH(4), .DIV(1), .MODMAX(9)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .out(b_out), .tick(b_tick), .tc(b_tc));
  updown_prescale_counter #(.WIDTH(4), .DIV(4), .MODMAX(15)) dut_c (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat(sat), .load(load),
    .load_val(load_val), .out(c_out), .tick(c_tick), .tc(c_tc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state, asynchronous and before any clock edge
    #3;
    chk("rst_a_out", a_out, 0);
    chk("rst_a_tc", a_tc, 0);
    chk("rst_c_presc", dut_c.r_presc, 0);
    en = 1'b1; load = 1'b1; load_val = 4'd5;
    step;
    chk("rst_over_load", c_out, 0);
    chk("rst_over_load_tc", b_tc, 0);
    load = 1'b0; rst = 1'b0;

    // free-running wrap 0..15,0,1
    en = 1'b1; dir = 1'b1; sat = 1'b0;
    chk("a_tick_eq_en", a_tick, 1);
    for (int k = 1; k <= 17; k++) begin
      step;
      chk($sformatf("wrap_out_%0d", k), a_out, k % 16);
      chk($sformatf("wrap_tc_%0d", k), a_tc, (k == 16) ? 1 : 0);
    end

    // divide-by-4 prescaler, then freeze
    en = 1'b0;
    rst_pulse;
    for (int c = 1; c <= 12; c++) begin
      en = 1'b1;
      #1;
      chk($sformatf("div_tick_%0d", c), c_tick, (c % 4 == 0) ? 1 : 0);
      step;
    end
    chk("div_out", c_out, 3);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("hold_tick", c_tick, 0);
      step;
      chk("hold_out", c_out, 3);
      chk("hold_presc", dut_c.r_presc, 0);
    end
    en = 1'b1;
    step; step;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step;
      chk("freeze_presc", dut_c.r_presc, 2);
      chk("freeze_out", c_out, 3);
    end
    en = 1'b1;
    #1 chk("resume_tick0", c_tick, 0);
    step;
    chk("resume_tick1", c_tick, 1);
    step;
    chk("resume_out", c_out, 4);

    // load clamps to MODMAX and beats a coincident tick
    step;
    chk("pre_load_presc", dut_c.r_presc, 1);
    dir = 1'b1; sat = 1'b0; load = 1'b1; load_val = 4'd12;
    #1 chk("load_tick", b_tick, 1);
    step;
    load = 1'b0;
    chk("load_clamp", b_out, 9);
    chk("load_tc", b_tc, 0);
    chk("load_presc_c", dut_c.r_presc, 0);
    chk("load_out_a", a_out, 12);
    step;
    chk("b_wrap_up", b_out, 0);
    chk("b_wrap_up_tc", b_tc, 1);
    step;
    chk("b_after_wrap", b_out, 1);
    chk("b_after_wrap_tc", b_tc, 0);

    // down saturation at 0 pulses tc every tick
    dir = 1'b0; sat = 1'b1; load = 1'b1; load_val = 4'd0;
    step;
    load = 1'b0;
    chk("dsat_start", b_out, 0);
    for (int t = 1; t <= 3; t++) begin
      step;
      chk($sformatf("dsat_out_%0d", t), b_out, 0);
      chk($sformatf("dsat_tc_%0d", t), b_tc, 1);
    end
    sat = 1'b0;
    step;
    chk("b_wrap_dn", b_out, 9);
    chk("b_wrap_dn_tc", b_tc, 1);
    step;
    chk("b_dn", b_out, 8);
    chk("b_dn_tc", b_tc, 0);

    // up saturation at MODMAX
    dir = 1'b1; sat = 1'b1; load = 1'b1; load_val = 4'd9;
    step;
    load = 1'b0;
    step;
    chk("usat_out", b_out, 9);
    chk("usat_tc", b_tc, 1);
    step;
    chk("usat_tc2", b_tc, 1);
    en = 1'b0;
    step;
    chk("idle_tc", b_tc, 0);
    chk("idle_out", b_out, 9);

    // asynchronous reset mid-count, held through a load edge
    load = 1'b1; load_val = 4'd7;
    step;
    load = 1'b0;
    chk("a_load7", a_out, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", a_out, 0);
    chk("arst_tc", a_tc, 0);
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    step;
    chk("arst_load_out", a_out, 0);
    load = 1'b0; sat = 1'b0;
    #2 rst = 1'b0;
    step;
    chk("arst_resume", a_out, 1);

    // random dir/sat changes between ticks; only tick-edge values matter
    en = 1'b0;
    rst_pulse;
    load = 1'b1; load_val = 4'd5;
    step;
    load = 1'b0; en = 1'b1;
    m_out = 5; m_p = 0;
    for (int i = 0; i < 30; i++) begin
      dir = 1'($urandom_range(0, 1));
      sat = (m_p == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      #1 chk("rnd_tick", c_tick, (m_p == 3) ? 1 : 0);
      step;
      if (m_p == 3) begin
        if (dir) m_out = (m_out == 15) ? 0 : m_out + 1;
        else     m_out = (m_out == 0) ? 15 : m_out - 1;
      end
      m_p = (m_p + 1) % 4;
      chk($sformatf("rnd_out_%0d", i), c_out, m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
